mem_arbiter: RTL and testbench

Arbitrates a single shared memory port between the hart's instruction-fetch requester and its data (load/store) requester, replacing the separate combinational imem/dmem ports with one request/ready/response memory. Sequences one outstanding transaction at a time: arbitrate, issue, wait for the response, then route the response back to the owner. Data accesses win ties. A starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IMEM = 2'd1,
        DMEM = 2'd2
    } owner_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;
    localparam int         CNT_W      = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational fetch/data tie-break with starvation counter update.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_imem_req,
    input  logic             i_dmem_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant_imem,
    output logic             o_grant_dmem,
    output logic [CNT_W-1:0] o_next_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        o_grant_imem = 1'b0;
        o_grant_dmem = 1'b0;
        o_next_cnt   = i_starve_cnt;
        if (i_imem_req && i_dmem_req) begin
            // Data wins ties until fetch has lost LIMIT times in a row.
            if (i_starve_cnt < LIMIT) begin
                o_grant_dmem = 1'b1;
                o_next_cnt   = i_starve_cnt + 1'b1;
            end else begin
                o_grant_imem = 1'b1;
                o_next_cnt   = '0;
            end
        end else if (i_imem_req) begin
            o_grant_imem = 1'b1;
            o_next_cnt   = '0;
        end else if (i_dmem_req) begin
            o_grant_dmem = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one request/ready/response memory port between fetch and data.
// Latency: request seen in cycle 0, issued in cycle 1, earliest response in cycle 2.
// Backpressure: holds the captured request on o_mem_* until i_mem_ready; one transaction in flight.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_rvalid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_proto_err
);

    state_t           r_state;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic             r_mem_wen;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_mask;
    logic             r_busy;
    logic             r_proto_err;

    logic             w_grant_imem;
    logic             w_grant_dmem;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_arb_en;
    logic             w_own_i;
    logic             w_own_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_imem_req   (i_imem_req),
        .i_dmem_req   (i_dmem_req),
        .i_starve_cnt (r_cnt),
        .o_grant_imem (w_grant_imem),
        .o_grant_dmem (w_grant_dmem),
        .o_next_cnt   (w_next_cnt)
    );

    // Re-arbitrating on the response edge avoids an IDLE bubble between transactions.
    assign w_arb_en = (r_state == IDLE) || ((r_state == WAIT) && i_mem_rvalid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_owner     <= NONE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (i_mem_rvalid && (r_state != WAIT)) begin
                r_proto_err <= 1'b1;
            end
            if ((r_state == ISSUE) && i_mem_ready) begin
                r_state   <= WAIT;
                r_mem_req <= 1'b0;
            end
            if (w_arb_en) begin
                r_cnt <= w_next_cnt;
                if (w_grant_imem || w_grant_dmem) begin
                    r_state     <= ISSUE;
                    r_busy      <= 1'b1;
                    r_mem_req   <= 1'b1;
                    r_owner     <= w_grant_imem ? IMEM : DMEM;
                    r_mem_addr  <= w_grant_imem ? i_imem_addr : i_dmem_addr;
                    r_mem_wen   <= w_grant_dmem & i_dmem_wen;
                    r_mem_wdata <= w_grant_imem ? 32'd0 : i_dmem_wdata;
                    r_mem_mask  <= w_grant_imem ? FETCH_MASK : i_dmem_mask;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_owner <= NONE;
                end
            end
        end
    end

    assign w_own_i = (r_owner == IMEM);
    assign w_own_d = (r_owner == DMEM);

    assign o_imem_ready  = (r_state == ISSUE) && w_own_i && i_mem_ready;
    assign o_dmem_ready  = (r_state == ISSUE) && w_own_d && i_mem_ready;
    assign o_imem_rvalid = (r_state == WAIT) && w_own_i && i_mem_rvalid;
    assign o_dmem_rvalid = (r_state == WAIT) && w_own_d && i_mem_rvalid;
    assign o_imem_rdata  = ((r_state == WAIT) && w_own_i) ? i_mem_rdata : 32'd0;
    assign o_dmem_rdata  = ((r_state == WAIT) && w_own_d) ? i_mem_rdata : 32'd0;

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;
    assign o_busy      = r_busy;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_imem_req, i_dmem_req, i_dmem_wen, i_mem_ready, i_mem_rvalid;
    logic [31:0] i_imem_addr, i_dmem_addr, i_dmem_wdata, i_mem_rdata;
    logic [3:0]  i_dmem_mask;
    logic        o_imem_ready, o_imem_rvalid, o_dmem_ready, o_dmem_rvalid;
    logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_req, o_mem_wen, o_busy, o_proto_err;
    logic [3:0]  o_mem_mask;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
        .o_imem_ready(o_imem_ready), .o_imem_rvalid(o_imem_rvalid), .o_imem_rdata(o_imem_rdata),
        .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_wen(i_dmem_wen),
        .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
        .o_dmem_ready(o_dmem_ready), .o_dmem_rvalid(o_dmem_rvalid), .o_dmem_rdata(o_dmem_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_proto_err(o_proto_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction in flight (none / offered / awaiting response),
    // who owns it, what was captured, and how many ties fetch has lost in a row.
    int          m_ph;
    bit          m_fetch;
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_addr, m_wdata;
    bit          m_wen;
    logic [3:0]  m_mask;
    bit          acc_i, acc_d, ipend, dpend;
    byte         dlog[$];

    task automatic m_reset();
        m_ph = 0; m_fetch = 0; m_cnt = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_wen = 0; m_mask = '0;
        acc_i = 0; acc_d = 0; ipend = 0; dpend = 0;
    endtask

    task automatic idle_in();
        i_imem_req = 0; i_imem_addr = '0; i_dmem_req = 0; i_dmem_addr = '0;
        i_dmem_wen = 0; i_dmem_wdata = '0; i_dmem_mask = '0;
        i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    endtask

    // Compare every output against the model for the current cycle's inputs.
    task automatic settle();
        bit e_rdy, e_rv, e_wait;
        #1;
        e_rdy  = (m_ph == 1) && i_mem_ready;
        e_rv   = (m_ph == 2) && i_mem_rvalid;
        e_wait = (m_ph == 2);
        chk("mem_req",     32'(o_mem_req),     32'(m_ph == 1));
        chk("busy",        32'(o_busy),        32'(m_ph != 0));
        chk("imem_ready",  32'(o_imem_ready),  32'(e_rdy && m_fetch));
        chk("dmem_ready",  32'(o_dmem_ready),  32'(e_rdy && !m_fetch));
        chk("imem_rvalid", 32'(o_imem_rvalid), 32'(e_rv && m_fetch));
        chk("dmem_rvalid", 32'(o_dmem_rvalid), 32'(e_rv && !m_fetch));
        chk("imem_rdata",  o_imem_rdata, (e_wait && m_fetch)  ? i_mem_rdata : 32'd0);
        chk("dmem_rdata",  o_dmem_rdata, (e_wait && !m_fetch) ? i_mem_rdata : 32'd0);
        chk("proto_err",   32'(o_proto_err),   32'(m_err));
        if (m_ph == 1) begin
            chk("mem_addr", o_mem_addr, m_addr);
            chk("mem_wen",  32'(o_mem_wen), 32'(m_wen));
            chk("mem_mask", 32'(o_mem_mask), 32'(m_mask));
            if (!m_fetch) chk("mem_wdata", o_mem_wdata, m_wdata);
        end
    endtask

    // Advance the model across the coming rising edge, then move to the next falling edge.
    task automatic tick();
        bit free, pick_i;
        int n_ph;
        acc_i = (m_ph == 1) && i_mem_ready && m_fetch;
        acc_d = (m_ph == 1) && i_mem_ready && !m_fetch;
        if (i_mem_rvalid && m_ph != 2) m_err = 1;
        n_ph = m_ph;
        if (m_ph == 1 && i_mem_ready) n_ph = 2;
        free = (m_ph == 0) || (m_ph == 2 && i_mem_rvalid);
        if (free) begin
            if (i_imem_req && i_dmem_req) pick_i = (m_cnt >= LIMIT);
            else                          pick_i = i_imem_req;
            if (i_imem_req || i_dmem_req) begin
                n_ph    = 1;
                m_fetch = pick_i;
                if (pick_i) begin
                    m_addr = i_imem_addr; m_wen = 0; m_mask = 4'hF; m_wdata = '0; m_cnt = 0;
                end else begin
                    m_addr = i_dmem_addr; m_wen = i_dmem_wen; m_mask = i_dmem_mask;
                    m_wdata = i_dmem_wdata;
                    if (i_imem_req) m_cnt++;
                end
            end else begin
                n_ph = 0;
            end
        end
        m_ph = n_ph;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit stray);
        i_rst_n = 0;
        idle_in();
        i_mem_rvalid = stray; i_mem_ready = stray; i_imem_req = stray; i_dmem_req = stray;
        i_mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_mem_req",   32'(o_mem_req), 0);
        chk("rst_mem_addr",  o_mem_addr, 0);
        chk("rst_mem_wen",   32'(o_mem_wen), 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_mem_mask",  32'(o_mem_mask), 0);
        chk("rst_ready",     32'({o_imem_ready, o_dmem_ready}), 0);
        chk("rst_rvalid",    32'({o_imem_rvalid, o_dmem_rvalid}), 0);
        chk("rst_rdata",     o_imem_rdata | o_dmem_rdata, 0);
        chk("rst_busy",      32'(o_busy), 0);
        chk("rst_proto_err", 32'(o_proto_err), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        i_rst_n = 1;
        idle_in();
    endtask

    task automatic drive_random();
        if (acc_i) ipend = 0;
        if (acc_d) dpend = 0;
        if (!ipend && $urandom_range(0, 2) == 0) begin
            ipend = 1;
            i_imem_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!dpend && $urandom_range(0, 2) == 0) begin
            dpend = 1;
            i_dmem_addr  = $urandom() & 32'hFFFF_FFFC;
            i_dmem_wen   = 1'($urandom_range(0, 1));
            i_dmem_wdata = $urandom();
            i_dmem_mask  = 4'($urandom_range(1, 15));
        end
        i_imem_req   = ipend;
        i_dmem_req   = dpend;
        i_mem_ready  = 1'($urandom_range(0, 1));
        i_mem_rvalid = (m_ph == 2) && ($urandom_range(0, 2) == 0);
        i_mem_rdata  = $urandom();
    endtask

    initial begin
        idle_in();
        m_reset();
        @(negedge clk);
        do_reset(0);

        // Single fetch: issue in cycle 1, response in cycle 3, idle in cycle 4.
        i_imem_req = 1; i_imem_addr = 32'h100; settle(); tick();
        i_mem_ready = 1; settle();
        chk("fetch_ready_c1", 32'(o_imem_ready), 1);
        chk("fetch_addr_c1", o_mem_addr, 32'h100);
        tick();
        i_imem_req = 0; i_mem_ready = 0; settle(); tick();
        i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF; settle();
        chk("fetch_rvalid_c3", 32'(o_imem_rvalid), 1);
        chk("fetch_rdata_c3", o_imem_rdata, 32'hDEAD_BEEF);
        tick();
        i_mem_rvalid = 0; settle();
        chk("fetch_idle_c4", 32'(o_busy), 0);
        tick();

        // Tie: data first, fetch issues the cycle after the data response.
        i_imem_req = 1; i_imem_addr = 32'h40;
        i_dmem_req = 1; i_dmem_addr = 32'h80; i_dmem_wen = 1;
        i_dmem_wdata = 32'h1234_5678; i_dmem_mask = 4'b0011;
        settle(); tick();
        i_mem_ready = 1; settle();
        chk("tie_wen", 32'(o_mem_wen), 1);
        chk("tie_mask", 32'(o_mem_mask), 32'h3);
        chk("tie_dready", 32'(o_dmem_ready), 1);
        tick();
        i_dmem_req = 0; i_mem_ready = 0; i_mem_rvalid = 1; settle();
        chk("tie_drvalid", 32'(o_dmem_rvalid), 1);
        tick();
        i_mem_rvalid = 0; i_mem_ready = 1; settle();
        chk("tie_fetch_req", 32'(o_mem_req), 1);
        chk("tie_fetch_addr", o_mem_addr, 32'h40);
        chk("tie_fetch_mask", 32'(o_mem_mask), 32'hF);
        tick();
        i_imem_req = 0; i_mem_ready = 0; i_mem_rvalid = 1; settle(); tick();
        i_mem_rvalid = 0; settle(); tick();

        // Starvation: both held continuously, memory answers as fast as allowed.
        do_reset(0);
        dlog.delete();
        i_imem_req = 1; i_imem_addr = 32'h300;
        i_dmem_req = 1; i_dmem_addr = 32'h400; i_dmem_wen = 0; i_dmem_mask = 4'hF;
        for (int c = 0; c < 2 * (LIMIT + 2) + 1; c++) begin
            i_mem_ready = (m_ph == 1); i_mem_rvalid = (m_ph == 2); i_mem_rdata = 32'(c);
            settle();
            if (o_imem_ready) dlog.push_back("I");
            if (o_dmem_ready) dlog.push_back("D");
            tick();
        end
        chk("starve_count", 32'(dlog.size()), 32'(LIMIT + 2));
        for (int k = 0; k < LIMIT + 2; k++) begin
            byte e;
            e = (k == LIMIT) ? "I" : "D";
            chk($sformatf("starve_grant%0d", k), (k < dlog.size()) ? 32'(dlog[k]) : 32'd0, 32'(e));
        end
        i_imem_req = 0; i_dmem_req = 0;
        for (int c = 0; c < 4; c++) begin
            i_mem_ready = (m_ph == 1); i_mem_rvalid = (m_ph == 2);
            settle(); tick();
        end
        i_mem_ready = 0; i_mem_rvalid = 0;

        // Backpressure: five cycles without i_mem_ready.
        i_dmem_req = 1; i_dmem_addr = 32'h500; i_dmem_wen = 0; i_dmem_mask = 4'hF;
        settle(); tick();
        for (int c = 0; c < 5; c++) begin
            i_mem_ready = 0; settle();
            chk("bp_addr", o_mem_addr, 32'h500);
            chk("bp_noready", 32'(o_dmem_ready), 0);
            tick();
        end
        i_mem_ready = 1; settle();
        chk("bp_ready", 32'(o_dmem_ready), 1);
        tick();
        i_dmem_req = 0; i_mem_ready = 0; i_mem_rvalid = 1; settle(); tick();
        i_mem_rvalid = 0; settle(); tick();

        // Store pass-through and ack routing.
        i_dmem_req = 1; i_dmem_addr = 32'h2000; i_dmem_wen = 1;
        i_dmem_wdata = 32'hAB00_0000; i_dmem_mask = 4'b1000;
        settle(); tick();
        i_mem_ready = 1; settle();
        chk("st_addr", o_mem_addr, 32'h2000);
        chk("st_wen", 32'(o_mem_wen), 1);
        chk("st_wdata", o_mem_wdata, 32'hAB00_0000);
        chk("st_mask", 32'(o_mem_mask), 32'h8);
        tick();
        i_dmem_req = 0; i_mem_ready = 0; i_mem_rvalid = 1; i_mem_rdata = '0; settle();
        chk("st_ack", 32'(o_dmem_rvalid), 1);
        chk("st_ack_not_fetch", 32'(o_imem_rvalid), 0);
        tick();
        i_mem_rvalid = 0; settle(); tick();

        // Reset while waiting, then a stale response.
        i_imem_req = 1; i_imem_addr = 32'h600; settle(); tick();
        i_mem_ready = 1; settle(); tick();
        i_imem_req = 0; i_mem_ready = 0; settle();
        chk("pre_reset_wait", 32'(o_busy), 1);
        tick();
        do_reset(1);
        i_mem_rvalid = 1; i_mem_rdata = 32'h5555_AAAA; settle();
        chk("stray_not_fwd", 32'(o_imem_rvalid), 0);
        tick();
        i_mem_rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("proto_err_sticky", 32'(o_proto_err), 1);
            tick();
        end

        // Randomized traffic.
        do_reset(0);
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
